// File: rtl/vga_stream_out.sv
// Streams a show-ahead FIFO onto a VGA raster: free-running h/v counters, registered syncs,
// and a frame FSM that starts whole lines only. Optional macro: VGA_STREAM_UNDERFLOW_CNT_EN.
module vga_stream_out #(
  parameter int H_TOTAL     = 480,
  parameter int H_SYNC      = 29,
  parameter int H_ACT_START = 52,
  parameter int H_ACT       = 400,
  parameter int V_TOTAL     = 347,
  parameter int V_SYNC      = 4,
  parameter int V_ACT_START = 13,
  parameter int V_ACT       = 320,
  parameter int PIX_W       = 24,
  parameter int USEDW_W     = 10,
  localparam int LN_W       = $clog2(V_ACT + 1)
) (
  input  logic               vga_clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [USEDW_W-1:0] fifo_usedw,
  input  logic [PIX_W-1:0]   fifo_rdata,
  output logic               fifo_read,
  output logic               vga_hsync,
  output logic               vga_vsync,
  output logic               vga_de,
  output logic [PIX_W-1:0]   vga_rgb,
  output logic               img_end,
  output logic               underflow,
`ifdef VGA_STREAM_UNDERFLOW_CNT_EN
  output logic [15:0]        underflow_cnt,
`endif
  output logic [1:0]         dbg_state,
  output logic [LN_W-1:0]    dbg_line_num
);

  localparam int H_W  = $clog2(H_TOTAL);
  localparam int V_W  = $clog2(V_TOTAL);
  localparam int PC_W = $clog2(H_ACT + 1);

  localparam logic [H_W-1:0]     H_LAST     = H_W'(H_TOTAL - 1);
  localparam logic [H_W-1:0]     H_TIMEOUT  = H_W'(H_TOTAL - 2);
  localparam logic [H_W-1:0]     H_SYNC_C   = H_W'(H_SYNC);
  localparam logic [H_W-1:0]     H_START_M1 = H_W'(H_ACT_START - 1);
  localparam logic [V_W-1:0]     V_LAST     = V_W'(V_TOTAL - 1);
  localparam logic [V_W-1:0]     V_SYNC_C   = V_W'(V_SYNC);
  localparam logic [V_W-1:0]     V_START_C  = V_W'(V_ACT_START);
  localparam logic [LN_W-1:0]    V_ACT_C    = LN_W'(V_ACT);
  localparam logic [PC_W-1:0]    PIX_LOAD   = PC_W'(H_ACT);
  localparam logic [PC_W-1:0]    PIX_ONE    = PC_W'(1);
  localparam logic [USEDW_W:0]   H_ACT_U    = (USEDW_W + 1)'(H_ACT);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_SOF = 2'd1,
    S_ACTIVE   = 2'd2,
    S_DONE     = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [H_W-1:0]   r_h_cnt;
  logic [V_W-1:0]   r_v_cnt;
  logic [LN_W-1:0]  r_line_num;
  logic [PC_W-1:0]  r_pix_cnt;
  logic             r_hsync;
  logic             r_vsync;
  logic             r_de;
  logic [PIX_W-1:0] r_rgb;
  logic             r_img_end;
  logic             r_underflow;

  logic w_h_last;
  logic w_v_last;
  logic w_sof;
  logic w_slot;
  logic w_fifo_ok;
  logic w_start_ok;
  logic w_start_fail;
  logic w_read;
  logic w_last_pix;
  logic w_timeout;
  logic w_uf_event;

  assign w_h_last     = (r_h_cnt == H_LAST);
  assign w_v_last     = (r_v_cnt == V_LAST);
  assign w_sof        = (r_state == S_WAIT_SOF) && (r_h_cnt == '0) && (r_v_cnt == '0);
  assign w_slot       = (r_state == S_ACTIVE) && (r_h_cnt == H_START_M1) &&
                        (r_v_cnt >= V_START_C) && (r_line_num != V_ACT_C);
  assign w_fifo_ok    = ({1'b0, fifo_usedw} >= H_ACT_U);
  assign w_start_ok   = w_slot && w_fifo_ok;
  assign w_start_fail = w_slot && !w_fifo_ok;
  assign w_read       = (r_pix_cnt != '0);
  assign w_last_pix   = (r_state == S_ACTIVE) && (r_pix_cnt == PIX_ONE) && (r_line_num == V_ACT_C);
  // Frame ran out of raster before all lines were delivered; leave cleanly before the wrap.
  assign w_timeout    = (r_state == S_ACTIVE) && w_v_last && (r_h_cnt == H_TIMEOUT) &&
                        (r_line_num < V_ACT_C);
  assign w_uf_event   = w_start_fail || w_timeout;

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (w_h_last) begin
      r_h_cnt <= '0;
      r_v_cnt <= w_v_last ? '0 : r_v_cnt + 1'b1;
    end else begin
      r_h_cnt <= r_h_cnt + 1'b1;
    end
  end

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:     if (enable) w_next_state = S_WAIT_SOF;
      S_WAIT_SOF: if (w_sof) w_next_state = S_ACTIVE;
      S_ACTIVE:   if (w_last_pix || w_timeout) w_next_state = S_DONE;
      S_DONE:     if (w_v_last && w_h_last) w_next_state = enable ? S_WAIT_SOF : S_IDLE;
      default:    w_next_state = S_IDLE;
    endcase
  end

  // A line is either granted all H_ACT reads up front or none at all.
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pix_cnt  <= '0;
      r_line_num <= '0;
      r_img_end  <= 1'b0;
    end else begin
      if (w_start_ok) begin
        r_pix_cnt <= PIX_LOAD;
      end else if (w_read) begin
        r_pix_cnt <= r_pix_cnt - 1'b1;
      end
      if (w_sof) begin
        r_line_num <= '0;
      end else if (w_start_ok) begin
        r_line_num <= r_line_num + 1'b1;
      end
      if (w_sof) begin
        r_img_end <= 1'b0;
      end else if (w_last_pix) begin
        r_img_end <= 1'b1;
      end
    end
  end

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hsync     <= 1'b0;
      r_vsync     <= 1'b0;
      r_de        <= 1'b0;
      r_rgb       <= '0;
      r_underflow <= 1'b0;
    end else begin
      r_hsync     <= (r_h_cnt >= H_SYNC_C);
      r_vsync     <= (r_v_cnt >= V_SYNC_C);
      r_de        <= w_read;
      r_rgb       <= w_read ? fifo_rdata : '0;
      r_underflow <= w_uf_event;
    end
  end

`ifdef VGA_STREAM_UNDERFLOW_CNT_EN
  logic [15:0] r_uf_cnt;

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_uf_cnt <= '0;
    end else if (w_uf_event && (r_uf_cnt != 16'hFFFF)) begin
      r_uf_cnt <= r_uf_cnt + 16'd1;
    end
  end

  assign underflow_cnt = r_uf_cnt;
`endif

  assign fifo_read    = w_read;
  assign vga_hsync    = r_hsync;
  assign vga_vsync    = r_vsync;
  assign vga_de       = r_de;
  assign vga_rgb      = r_rgb;
  assign img_end      = r_img_end;
  assign underflow    = r_underflow;
  assign dbg_state    = r_state;
  assign dbg_line_num = r_line_num;

endmodule

// File: tb/tb_vga_stream_out.sv
// Bench for vga_stream_out on a shrunken raster; a cycle-indexed frame model predicts every
// output, a ramp FIFO feeds pixels, and literal checks pin whole-frame totals.
module tb_vga_stream_out;

  localparam int HT  = 40;
  localparam int HS  = 4;
  localparam int HAS = 8;
  localparam int HA  = 20;
  localparam int VT  = 30;
  localparam int VS  = 2;
  localparam int VAS = 3;
  localparam int VA  = 16;
  localparam int PW  = 16;
  localparam int UW  = 6;
  localparam int LNW = $clog2(VA + 1);

  localparam int P_IDLE = 0;
  localparam int P_WAIT = 1;
  localparam int P_ACT  = 2;
  localparam int P_DONE = 3;

  logic          vga_clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic [UW-1:0] fifo_usedw = '0;
  logic [PW-1:0] fifo_rdata = '0;
  logic          fifo_read;
  logic          vga_hsync;
  logic          vga_vsync;
  logic          vga_de;
  logic [PW-1:0] vga_rgb;
  logic          img_end;
  logic          underflow;
  logic [1:0]    dbg_state;
  logic [LNW-1:0] dbg_line_num;
`ifdef VGA_STREAM_UNDERFLOW_CNT_EN
  logic [15:0]   underflow_cnt;
`endif

  vga_stream_out #(
    .H_TOTAL(HT), .H_SYNC(HS), .H_ACT_START(HAS), .H_ACT(HA),
    .V_TOTAL(VT), .V_SYNC(VS), .V_ACT_START(VAS), .V_ACT(VA),
    .PIX_W(PW), .USEDW_W(UW)
  ) dut (
    .vga_clk      (vga_clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .fifo_usedw   (fifo_usedw),
    .fifo_rdata   (fifo_rdata),
    .fifo_read    (fifo_read),
    .vga_hsync    (vga_hsync),
    .vga_vsync    (vga_vsync),
    .vga_de       (vga_de),
    .vga_rgb      (vga_rgb),
    .img_end      (img_end),
    .underflow    (underflow),
`ifdef VGA_STREAM_UNDERFLOW_CNT_EN
    .underflow_cnt(underflow_cnt),
`endif
    .dbg_state    (dbg_state),
    .dbg_line_num (dbg_line_num)
  );

  // clock / reset
  always #5 vga_clk = ~vga_clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // reference model: cycle k since reset release gives h = k % HT, v = (k / HT) % VT
  int  m_k = 0;
  int  m_phase = P_IDLE;
  int  m_lines = 0;
  bit  m_img = 1'b0;
  bit  m_gv = 1'b0;
  int  m_gk = 0;
  int  m_uf = 0;
  bit  e_read = 1'b0, e_de = 1'b0, e_hs = 1'b0, e_vs = 1'b0, e_img = 1'b0, e_uf = 1'b0;
  int  e_state = P_IDLE;
  int  e_lines = 0;
  logic [PW-1:0] exp_q[$];

  always @(posedge vga_clk or negedge rst_n) begin : model
    int h, v, np;
    bit rd, uf;
    if (!rst_n) begin
      m_k = 0; m_phase = P_IDLE; m_lines = 0; m_img = 1'b0; m_gv = 1'b0; m_gk = 0; m_uf = 0;
      exp_q.delete();
      e_read = 1'b0; e_de = 1'b0; e_hs = 1'b0; e_vs = 1'b0; e_img = 1'b0; e_uf = 1'b0;
      e_state = P_IDLE; e_lines = 0;
    end else begin
      h  = m_k % HT;
      v  = (m_k / HT) % VT;
      rd = m_gv && (m_k > m_gk) && (m_k <= m_gk + HA);
      uf = 1'b0;
      np = m_phase;
      if (rd) exp_q.push_back(fifo_rdata);
      case (m_phase)
        P_IDLE: if (enable) np = P_WAIT;
        P_WAIT: if (h == 0 && v == 0) begin np = P_ACT; m_lines = 0; m_img = 1'b0; end
        P_ACT: begin
          if (h == HAS - 1 && v >= VAS && m_lines < VA) begin
            if (int'(fifo_usedw) >= HA) begin m_gv = 1'b1; m_gk = m_k; m_lines++; end
            else uf = 1'b1;
          end
          if (rd && m_k == m_gk + HA && m_lines == VA) begin m_img = 1'b1; np = P_DONE; end
          if (v == VT - 1 && h == HT - 2 && m_lines < VA) begin np = P_DONE; uf = 1'b1; end
        end
        P_DONE: if (v == VT - 1 && h == HT - 1) np = enable ? P_WAIT : P_IDLE;
        default: np = P_IDLE;
      endcase
      if (uf) m_uf++;
      m_phase = np;
      e_hs = (h >= HS); e_vs = (v >= VS); e_de = rd; e_uf = uf; e_img = m_img;
      e_state = np; e_lines = m_lines;
      m_k++;
      e_read = m_gv && (m_k > m_gk) && (m_k <= m_gk + HA);
    end
  end

  // scoreboard / monitor
  int mon_de = 0, mon_img = 0, mon_uf = 0, mon_hs = 0;
  bit prev_img = 1'b0, prev_hs = 1'b0;
  logic [PW-1:0] de_log[$];

  always @(negedge vga_clk) begin : compare
    logic [PW-1:0] want;
    check("outputs{read,de,hs,vs,img,uf}",
          {fifo_read, vga_de, vga_hsync, vga_vsync, img_end, underflow},
          {e_read, e_de, e_hs, e_vs, e_img, e_uf});
    check("state", dbg_state, e_state);
    check("line_num", dbg_line_num, e_lines);
    want = '0;
    if (e_de) begin
      check("exp_q_nonempty", (exp_q.size() != 0), 1);
      if (exp_q.size() != 0) want = exp_q.pop_front();
    end
    check("rgb", vga_rgb, want);
    if (vga_de) begin mon_de++; de_log.push_back(vga_rgb); end
    if (img_end && !prev_img) mon_img++;
    if (underflow) mon_uf++;
    if (vga_hsync && !prev_hs) mon_hs++;
    prev_img = img_end;
    prev_hs  = vga_hsync;
  end

  // FIFO driver: ramp data, head advances after each pop edge
  initial begin : fifo_drv
    logic [PW-1:0] ramp;
    bit pend;
    ramp = '0;
    pend = 1'b0;
    fifo_rdata = ramp;
    forever begin
      @(negedge vga_clk);
      if (pend) ramp = ramp + 1'b1;
      pend = fifo_read;
      fifo_rdata = ramp;
    end
  end

  // umode 0: usedw random >= HA, 1: random 0..40, 2: stuck at 0
  task automatic run_to(input int target, input int umode, input int uf_k, input int drop_k);
    int g;
    g = 0;
    while (m_k < target && g < 30000) begin
      if (m_k == drop_k) enable = 1'b0;
      case (umode)
        0:       fifo_usedw = UW'($urandom_range(HA, 40));
        1:       fifo_usedw = UW'($urandom_range(0, 40));
        default: fifo_usedw = '0;
      endcase
      if (m_k == uf_k) fifo_usedw = UW'(HA - 1);
      @(negedge vga_clk);
      g++;
    end
    check("run_to_cycle", m_k, target);
  endtask

  int b_de, b_img, b_uf, b_hs, b_muf;

  task automatic snap();
    b_de = mon_de; b_img = mon_img; b_uf = mon_uf; b_hs = mon_hs; b_muf = m_uf;
  endtask

  initial begin : watchdog
    #2_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : stim
    enable = 1'b1;
    fifo_usedw = UW'(40);
    repeat (3) @(negedge vga_clk);
    check("rst_fifo_read", fifo_read, 0);
    check("rst_vga_de", vga_de, 0);
    check("rst_vga_rgb", vga_rgb, 0);
    check("rst_hsync", vga_hsync, 0);
    check("rst_vsync", vga_vsync, 0);
    check("rst_img_end", img_end, 0);
    check("rst_underflow", underflow, 0);
    check("rst_state", dbg_state, P_IDLE);
    rst_n = 1'b1;

    // Frame 1: cycles 1200..2399 active window, FIFO always deep enough
    snap();
    run_to(2390, 0, -1, -1);
    check("f1_de_total", mon_de - b_de, 320);
    check("f1_img_rises", mon_img - b_img, 1);
    check("f1_underflows", mon_uf - b_uf, 0);
    check("f1_first_rgb", de_log[0], 0);
    check("f1_20th_rgb", de_log[19], 19);
    check("f1_line_num", dbg_line_num, 16);
    check("f1_img_end_level", img_end, 1);
    check("f1_state_done", dbg_state, P_DONE);

    // Frame 2: usedw short by one at the line-5 start slot
    snap();
    run_to(3590, 0, 2400 + 5 * HT + HAS - 1, -1);
    check("f2_underflows", mon_uf - b_uf, 1);
    check("f2_de_total", mon_de - b_de, 320);
    check("f2_img_rises", mon_img - b_img, 1);
    check("f2_first_rgb", de_log[320], 320);

    // Frame 3: random fill level
    snap();
    run_to(4790, 1, -1, -1);
    check("f3_underflows_vs_model", mon_uf - b_uf, m_uf - b_muf);

    // Frame 4: enable dropped at line 8, frame still completes
    snap();
    run_to(5990, 0, -1, 4800 + 8 * HT);
    check("f4_de_total", mon_de - b_de, 320);
    check("f4_img_rises", mon_img - b_img, 1);
    snap();
    run_to(7190, 0, -1, -1);
    check("f5_de_total_idle", mon_de - b_de, 0);
    check("f5_hsync_rises", mon_hs - b_hs, 30);
    check("f5_state_idle", dbg_state, P_IDLE);

    // Frame 6: reset in the middle of line 3
    enable = 1'b1;
    run_to(7200 + (VAS + 2) * HT + HAS + 10, 0, -1, -1);
    check("f6_reading_before_rst", fifo_read, 1);
    @(posedge vga_clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_fifo_read", fifo_read, 0);
    check("midrst_vga_de", vga_de, 0);
    check("midrst_vga_rgb", vga_rgb, 0);
    check("midrst_hsync", vga_hsync, 0);
    fifo_usedw = '0;
    @(negedge vga_clk);
    @(negedge vga_clk);
    rst_n = 1'b1;

    // After release: wait for start of frame, then a frame with an empty FIFO
    snap();
    run_to(5, 2, -1, -1);
    check("post_rst_wait_sof", dbg_state, P_WAIT);
    run_to(2405, 2, -1, -1);
    check("starved_underflows", mon_uf - b_uf, 28);
    check("starved_underflows_vs_model", mon_uf - b_uf, m_uf);
    check("starved_de_total", mon_de - b_de, 0);
    check("starved_img_rises", mon_img - b_img, 0);
`ifdef VGA_STREAM_UNDERFLOW_CNT_EN
    check("underflow_cnt", underflow_cnt, 28);
    check("underflow_cnt_vs_model", underflow_cnt, m_uf);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
